ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port sequencer for the shared 16-bit block RAM. Accepts word read/write requests from the CPU (port 0) and a secondary master such as DMA or video fetch (port 1), arbitrates between them, and drives the RAM's enable/write/read/address strobes and its bidirectional data bus. Sits between the masters and the RAM, whose reads are registered and return on the bus one cycle after the access.

## Interface
- `RAM_BUS_SIZE`, 11: RAM address width in words.
- `DATA_WIDTH`, 16: word width; must match the RAM.
- `clk` in 1: system clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `req0` / `req1` in 1: request from port 0 / port 1; held high until that port's ack.
- `we0` / `we1` in 1: 1 = write, 0 = read; stable while req high.
- `addr0` / `addr1` in RAM_BUS_SIZE: word address; stable while req high.
- `wdata0` / `wdata1` in DATA_WIDTH: write data; stable while req high.
- `ack0` / `ack1` out 1: one-cycle completion pulse.
- `rdata` out DATA_WIDTH: read result, shared by both ports; valid in the ack cycle of a read and held until the next read completes.
- `ram_enable` out 1: RAM access strobe.
- `ram_write` out 1: RAM write select.
- `ram_read` out 1: RAM output-drive enable.
- `ram_address` out RAM_BUS_SIZE: RAM word address.
- `ram_data` inout DATA_WIDTH: RAM data bus.

## Operation
- FSM states: IDLE, ACCESS, READ, DONE.
- IDLE:
  - All RAM strobes 0; `ram_data` released to Z.
  - On the rising edge with any req high, pick a winner.
  - Latch the winner's we/addr/wdata and its port index.
  - Go to ACCESS.
- ACCESS, one cycle:
  - `ram_enable`=1; `ram_write`=latched we; `ram_address`=latched addr.
  - For writes, `ram_data` is driven with the latched wdata. For reads it stays Z.
  - Next state: DONE for a write, READ for a read.
- READ, one cycle:
  - `ram_read`=1, `ram_enable`=0. The RAM drives the word it latched at the end of ACCESS.
  - `rdata` captures `ram_data` on the closing edge.
  - Next state: DONE.
- DONE, one cycle:
  - The ack of the latched port is 1 and all strobes are 0.
  - Next state: IDLE, unconditionally.
- Arbitration when both req are high in IDLE uses a round-robin pointer. The port not granted last wins. The pointer updates on every grant.
- A single requester always wins, regardless of the pointer.
- The controller never drives `ram_data` while `ram_read`=1. The RAM and the controller must never both drive the bus.
- Requester rule: drop req (or re-present a new request) on the edge that ends its ack cycle. A req still high in IDLE is treated as a new request.

## Timing
- Request sampled at edge E0.
- Write: ACCESS in cycle E0+1, ack in cycle E0+2. Total 2 cycles from sample to ack.
- Read: ACCESS in E0+1, READ in E0+2, ack and valid `rdata` in E0+3. Total 3 cycles.
- Minimum of one IDLE cycle between transactions. Peak throughput is one write per 3 cycles or one read per 4 cycles.
- Reset values:
  - state IDLE; round-robin pointer set so port 0 wins the first contention.
  - `ack0`/`ack1`/`ram_enable`/`ram_write`/`ram_read` = 0; `ram_address` = 0; `rdata` = 0.
  - `ram_data` = Z.
- Reset mid-transaction aborts it, with no ack issued.
  - A write aborted in ACCESS may or may not have reached the RAM.
  - The requester must reissue after reset.
- All outputs are registered or decoded from state plus latched registers. Nothing is combinational from the req inputs.

## Configuration
- `RAM_ARBITER_FIXED_PRIO_EN`:
  - Defined: port 0 (CPU) always wins contention. The round-robin pointer is not implemented.
  - Undefined (default): round-robin as above.
- Latency and all other behaviour are identical in both builds.

## Structure
- Shared include/package `ram_arbiter_pkg`: FSM state encodings (ST_IDLE, ST_ACCESS, ST_READ, ST_DONE) and the port index constants.
- One natural sub-module, `ram_arb_pick`:
  - Inputs: req0, req1, pointer.
  - Outputs: grant valid and winner index.
  - Holds the `RAM_ARBITER_FIXED_PRIO_EN` switch.
- Bench uses the existing RAM model as the real slave.

## Test plan
- Port 0 writes 0xBEEF at 0x010, then reads 0x010. Ack0 at E0+2 for the write; `rdata`=0xBEEF with ack0 at E0+3 for the read. ack1 stays 0.
- Both ports request reads in the same IDLE cycle after reset. Port 0 is served first, then port 1. With both held continuously, grants alternate 0,1,0,1.
- Same contention with `RAM_ARBITER_FIXED_PRIO_EN`. Port 0 is served every transaction while its req stays high; port 1 is starved until port 0 drops req.
- Read of 0x7FF (top address) after a write of 0x1234 there returns 0x1234. Bus check: `ram_data` is never driven by the controller while `ram_read`=1.
- Assert reset during a READ cycle. The next cycle shows IDLE, all strobes 0, no ack, `rdata`=0. A reissued read then completes normally.
- Port 1 write of 0xA5A5 at 0x000. `ram_write`=1 for exactly one cycle with `ram_data`=0xA5A5, then ack1 one cycle later. A port 0 request arriving mid-transaction waits for IDLE.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port block RAM sequencer: FSM state encodings
// and port index constants.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_READ   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/ram_arb_pick.sv
// Winner selection between the two request ports. Build option
// RAM_ARBITER_FIXED_PRIO_EN makes port 0 win every contention; otherwise round-robin.
module ram_arb_pick
  import ram_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic pointer,
  output logic grant_valid,
  output logic winner
);

`ifdef RAM_ARBITER_FIXED_PRIO_EN
  logic unused_pointer;
  assign unused_pointer = pointer;

  always_comb begin
    grant_valid = req0 | req1;
    winner      = req0 ? PORT0 : PORT1;
  end
`else
  // pointer holds the port granted last; on contention the other port wins
  always_comb begin
    grant_valid = req0 | req1;
    if (req0 && req1) begin
      winner = (pointer == PORT0) ? PORT1 : PORT0;
    end else begin
      winner = req0 ? PORT0 : PORT1;
    end
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Two-port sequencer for the shared block RAM with registered reads.
// Build option RAM_ARBITER_FIXED_PRIO_EN selects fixed port-0 priority instead of round-robin.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int RAM_BUS_SIZE = 11,
  parameter int DATA_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req0,
  input  logic                    req1,
  input  logic                    we0,
  input  logic                    we1,
  input  logic [RAM_BUS_SIZE-1:0] addr0,
  input  logic [RAM_BUS_SIZE-1:0] addr1,
  input  logic [DATA_WIDTH-1:0]   wdata0,
  input  logic [DATA_WIDTH-1:0]   wdata1,
  output logic                    ack0,
  output logic                    ack1,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    ram_enable,
  output logic                    ram_write,
  output logic                    ram_read,
  output logic [RAM_BUS_SIZE-1:0] ram_address,
  inout  wire  [DATA_WIDTH-1:0]   ram_data
);

  state_t                  state_reg;
  state_t                  state_next;
  logic                    we_reg;
  logic [RAM_BUS_SIZE-1:0] addr_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic                    port_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg;
  logic                    last_grant;
  logic                    grant_valid;
  logic                    winner;
  logic                    drive_en;
  logic                    grant;

  assign grant = (state_reg == ST_IDLE) && grant_valid;

  ram_arb_pick u_pick (
    .req0        (req0),
    .req1        (req1),
    .pointer     (last_grant),
    .grant_valid (grant_valid),
    .winner      (winner)
  );

`ifdef RAM_ARBITER_FIXED_PRIO_EN
  assign last_grant = PORT1;
`else
  logic last_grant_reg;

  // reset to PORT1 so that port 0 wins the first contention
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_reg <= PORT1;
    end else if (grant) begin
      last_grant_reg <= winner;
    end
  end

  assign last_grant = last_grant_reg;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (grant_valid) state_next = ST_ACCESS;
      ST_ACCESS: state_next = we_reg ? ST_DONE : ST_READ;
      ST_READ:   state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ram_enable = 1'b0;
    ram_write  = 1'b0;
    ram_read   = 1'b0;
    drive_en   = 1'b0;
    ack0       = 1'b0;
    ack1       = 1'b0;
    case (state_reg)
      ST_ACCESS: begin
        ram_enable = 1'b1;
        ram_write  = we_reg;
        drive_en   = we_reg;
      end
      ST_READ:   ram_read = 1'b1;
      ST_DONE: begin
        ack0 = (port_reg == PORT0);
        ack1 = (port_reg == PORT1);
      end
      default: ;
    endcase
  end

  // request latch and read-data capture
  always_ff @(posedge clk) begin
    if (reset) begin
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      port_reg  <= PORT0;
      rdata_reg <= '0;
    end else begin
      if (grant) begin
        port_reg  <= winner;
        we_reg    <= (winner == PORT1) ? we1 : we0;
        addr_reg  <= (winner == PORT1) ? addr1 : addr0;
        wdata_reg <= (winner == PORT1) ? wdata1 : wdata0;
      end
      if (state_reg == ST_READ) begin
        rdata_reg <= ram_data;
      end
    end
  end

  assign ram_address = addr_reg;
  assign rdata       = rdata_reg;
  assign ram_data    = drive_en ? wdata_reg : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a registered-read RAM model
// on the shared bus; expectations follow RAM_ARBITER_FIXED_PRIO_EN when defined.
module tb_ram_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [10:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [15:0] rdata;
  logic        ram_enable, ram_write, ram_read;
  logic [10:0] ram_address;
  wire  [15:0] ram_data;

  int total = 0;
  int bad   = 0;

  ram_arbiter #(.RAM_BUS_SIZE(11), .DATA_WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0        (req0),
    .req1        (req1),
    .we0         (we0),
    .we1         (we1),
    .addr0       (addr0),
    .addr1       (addr1),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .ack0        (ack0),
    .ack1        (ack1),
    .rdata       (rdata),
    .ram_enable  (ram_enable),
    .ram_write   (ram_write),
    .ram_read    (ram_read),
    .ram_address (ram_address),
    .ram_data    (ram_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: synchronous write, registered read driven while ram_read is high
  logic [15:0] mem [0:2047];
  logic [15:0] ram_q;
  initial ram_q = 16'h0;
  always @(posedge clk) begin
    if (ram_enable) begin
      if (ram_write) mem[ram_address] <= ram_data;
      else           ram_q <= mem[ram_address];
    end
  end
  assign ram_data = (ram_read && !ram_enable) ? ram_q : 16'bz;

  // bus ownership: during ram_read the bus must carry only the RAM's word
  always @(negedge clk) begin
    if (ram_read) begin
      total++;
      if (ram_data !== ram_q || ram_enable !== 1'b0) begin
        bad++;
        $display("FAIL bus_during_read: got data=%h en=%b want data=%h en=0", ram_data, ram_enable, ram_q);
      end
    end
  end

  task automatic run_txn(input logic port, input logic we, input logic [10:0] addr,
                         input logic [15:0] wd, output int lat, output logic [15:0] rd,
                         output logic cross_ack);
    if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd; end
    else      begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd; end
    lat = 0; rd = 16'h0; cross_ack = 1'b0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (port ? ack0 : ack1) cross_ack = 1'b1;
      if (port ? ack1 : ack0) begin rd = rdata; break; end
    end
    @(posedge clk); #1;
    if (port) req1 = 1'b0; else req0 = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (ack0 !== 1'b0 || ack1 !== 1'b0) begin bad++; $display("FAIL rst_ack: got %b%b want 00", ack0, ack1); end
    total++; if ({ram_enable, ram_write, ram_read} !== 3'b000) begin bad++; $display("FAIL rst_strobes: got %b want 000", {ram_enable, ram_write, ram_read}); end
    total++; if (ram_address !== 11'h0) begin bad++; $display("FAIL rst_addr: got %h want 000", ram_address); end
    total++; if (rdata !== 16'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0000", rdata); end
    reset = 1'b0;
    $display("reset: strobes=%b rdata=%h", {ram_enable, ram_write, ram_read}, rdata);
  endtask

  task automatic test_write_read_port0;
    int lat; logic [15:0] rd; logic x;
    run_txn(1'b0, 1'b1, 11'h010, 16'hBEEF, lat, rd, x);
    $display("p0 write 010=beef lat=%0d", lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL p0_write_lat: got %0d want 2", lat); end
    total++; if (x !== 1'b0) begin bad++; $display("FAIL p0_write_ack1: got %b want 0", x); end
    run_txn(1'b0, 1'b0, 11'h010, 16'h0, lat, rd, x);
    $display("p0 read 010 lat=%0d rdata=%h", lat, rd);
    total++; if (lat !== 3) begin bad++; $display("FAIL p0_read_lat: got %0d want 3", lat); end
    total++; if (rd !== 16'hBEEF) begin bad++; $display("FAIL p0_read_data: got %h want beef", rd); end
    total++; if (x !== 1'b0) begin bad++; $display("FAIL p0_read_ack1: got %b want 0", x); end
  endtask

  task automatic test_top_address;
    int lat; logic [15:0] rd; logic x;
    run_txn(1'b0, 1'b1, 11'h7FF, 16'h1234, lat, rd, x);
    total++; if (lat !== 2) begin bad++; $display("FAIL top_write_lat: got %0d want 2", lat); end
    run_txn(1'b1, 1'b0, 11'h7FF, 16'h0, lat, rd, x);
    $display("p1 read 7ff lat=%0d rdata=%h", lat, rd);
    total++; if (rd !== 16'h1234) begin bad++; $display("FAIL top_read_data: got %h want 1234", rd); end
    total++; if (lat !== 3) begin bad++; $display("FAIL top_read_lat: got %0d want 3", lat); end
  endtask

  task automatic test_port1_write;
    req1 = 1'b1; we1 = 1'b1; addr1 = 11'h000; wdata1 = 16'hA5A5;
    @(posedge clk); #1;
    total++; if ({ram_enable, ram_write} !== 2'b11) begin bad++; $display("FAIL p1w_access_strobes: got %b want 11", {ram_enable, ram_write}); end
    total++; if (ram_data !== 16'hA5A5) begin bad++; $display("FAIL p1w_bus: got %h want a5a5", ram_data); end
    total++; if (ram_address !== 11'h000) begin bad++; $display("FAIL p1w_addr: got %h want 000", ram_address); end
    req0 = 1'b1; we0 = 1'b0; addr0 = 11'h000;
    @(posedge clk); #1;
    total++; if ({ack1, ack0, ram_write} !== 3'b100) begin bad++; $display("FAIL p1w_done: got ack1/ack0/wr=%b want 100", {ack1, ack0, ram_write}); end
    @(posedge clk); #1;
    req1 = 1'b0;
    total++; if ({ram_enable, ack0, ack1} !== 3'b000) begin bad++; $display("FAIL p1w_idle: got en/ack0/ack1=%b want 000", {ram_enable, ack0, ack1}); end
    @(posedge clk); #1;
    total++; if ({ram_enable, ram_write, ram_address} !== {2'b10, 11'h000}) begin bad++; $display("FAIL p0_wait_access: got en/wr=%b addr=%h want 10/000", {ram_enable, ram_write}, ram_address); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (ack0 !== 1'b1 || rdata !== 16'hA5A5) begin bad++; $display("FAIL p0_wait_read: got ack0=%b rdata=%h want 1/a5a5", ack0, rdata); end
    $display("p1 write 000=a5a5 then p0 read rdata=%h", rdata);
    @(posedge clk); #1;
    req0 = 1'b0;
  endtask

  task automatic test_contention;
    int lat; logic [15:0] rd; logic x;
    logic exp_port [4];
    int n; int cyc; logic got;
`ifdef RAM_ARBITER_FIXED_PRIO_EN
    exp_port = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_port = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    run_txn(1'b0, 1'b1, 11'h020, 16'h1111, lat, rd, x);
    run_txn(1'b1, 1'b1, 11'h030, 16'h2222, lat, rd, x);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 11'h020;
    req1 = 1'b1; we1 = 1'b0; addr1 = 11'h030;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (ack0 || ack1) begin
        got = ack1;
        $display("contention grant %0d: port=%0d rdata=%h", n, got, rdata);
        total++; if (got !== exp_port[n]) begin bad++; $display("FAIL cont_order_%0d: got port %0d want %0d", n, got, exp_port[n]); end
        total++; if (rdata !== (got ? 16'h2222 : 16'h1111)) begin bad++; $display("FAIL cont_data_%0d: got %h want %h", n, rdata, got ? 16'h2222 : 16'h1111); end
        n++;
      end
    end
    total++; if (n != 4) begin bad++; $display("FAIL cont_timeout: got %0d acks want 4", n); end
    @(posedge clk); #1;
    req0 = 1'b0;
    cyc = 0;
    while (!(ack0 || ack1) && cyc < 20) begin @(posedge clk); #1; cyc++; end
    $display("after req0 drop: ack0=%b ack1=%b rdata=%h", ack0, ack1, rdata);
    total++; if ({ack0, ack1} !== 2'b01 || rdata !== 16'h2222) begin bad++; $display("FAIL cont_p1_after_drop: got ack0/ack1=%b rdata=%h want 01/2222", {ack0, ack1}, rdata); end
    @(posedge clk); #1;
    req1 = 1'b0;
  endtask

  task automatic test_reset_mid_read;
    int lat; logic [15:0] rd; logic x; int cyc;
    req0 = 1'b1; we0 = 1'b0; addr0 = 11'h010;
    cyc = 0;
    while (!ram_read && cyc < 10) begin @(posedge clk); #1; cyc++; end
    total++; if (ram_read !== 1'b1) begin bad++; $display("FAIL midrst_reach_read: got %b want 1", ram_read); end
    reset = 1'b1; req0 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    total++; if ({ram_enable, ram_write, ram_read, ack0, ack1} !== 5'b0) begin bad++; $display("FAIL midrst_strobes: got %b want 00000", {ram_enable, ram_write, ram_read, ack0, ack1}); end
    total++; if (rdata !== 16'h0) begin bad++; $display("FAIL midrst_rdata: got %h want 0000", rdata); end
    @(posedge clk); #1;
    total++; if ({ram_enable, ack0, ack1} !== 3'b0) begin bad++; $display("FAIL midrst_no_ack: got %b want 000", {ram_enable, ack0, ack1}); end
    run_txn(1'b0, 1'b0, 11'h010, 16'h0, lat, rd, x);
    $display("reissued read 010 lat=%0d rdata=%h", lat, rd);
    total++; if (lat !== 3 || rd !== 16'hBEEF) begin bad++; $display("FAIL midrst_reissue: got lat=%0d rdata=%h want 3/beef", lat, rd); end
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    test_reset;
    test_write_read_port0;
    test_top_address;
    test_port1_write;
    test_contention;
    test_reset_mid_read;
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
